// File: rtl/bus_select_arbiter_if.sv
// Bus-select handshake bundle between the control unit's out-enables and the bus mux select.
// master: drives req/hold, observes the registered grant. slave: the arbiter side.
// Ports: req[NUM_SRC], hold -> arbiter; select_code[SEL_W], grant_onehot[NUM_SRC], grant_valid, conflict <- arbiter.
interface bus_select_arbiter_if #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
);
  logic [NUM_SRC-1:0] req;
  logic               hold;
  logic [SEL_W-1:0]   select_code;
  logic [NUM_SRC-1:0] grant_onehot;
  logic               grant_valid;
  logic               conflict;

  modport master (
    output req, hold,
    input  select_code, grant_onehot, grant_valid, conflict
  );

  modport slave (
    input  req, hold,
    output select_code, grant_onehot, grant_valid, conflict
  );
endinterface

// File: rtl/bus_select_arbiter.sv
// Round-robin arbiter for 24 bus sources; encodes the winner into the bus-mux select code.
// Latency: req/hold sampled at edge N, grant registered and valid for cycle N+1; all outputs are flops.
// Backpressure: none; 'hold' extends ownership, bounded to MAX_HOLD cycles while others are pending.
// Ports: clk, clr_n (async active-low), bus (slave modport: req, hold in; select_code,
//        grant_onehot, grant_valid, conflict out).
module bus_select_arbiter #(
  parameter int               NUM_SRC   = 24,
  parameter int               SEL_W     = 5,
  parameter int               MAX_HOLD  = 8,
  parameter logic [SEL_W-1:0] IDLE_CODE = 5'b11111
) (
  input  logic                 clk,
  input  logic                 clr_n,
  bus_select_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]   select_code_q, select_code_d;
  logic [NUM_SRC-1:0] grant_onehot_q, grant_onehot_d;
  logic               grant_valid_q, grant_valid_d;
  logic               conflict_q, conflict_d;

  logic               others_pending;
  logic               limit_hit;
  logic               keep;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     scan_idx;

  always_comb begin
    others_pending = 1'b0;
    limit_hit      = 1'b0;
    keep           = 1'b0;
    found          = 1'b0;
    winner         = '0;
    scan_idx       = '0;

    ptr_d          = ptr_q;
    cur_d          = cur_q;
    hold_cnt_d     = '0;
    select_code_d  = IDLE_CODE;
    grant_onehot_d = '0;
    grant_valid_d  = 1'b0;
    conflict_d     = ($countones(bus.req) > 1);

    // While a grant is live, grant_onehot_q marks cur, so masking it off leaves the competitors.
    others_pending = |(bus.req & ~grant_onehot_q);
    limit_hit      = (hold_cnt_q == HOLD_LAST) && others_pending;
    keep           = grant_valid_q && bus.hold && bus.req[cur_q] && !limit_hit;

    // Rotating scan from ptr. ptr is always cur+1 after a grant, so a forced release
    // naturally starts the scan just past the current owner.
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_idx = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (scan_idx >= (IDX_W+1)'(NUM_SRC)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NUM_SRC);
      end
      if (!found && bus.req[scan_idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDX_W-1:0];
      end
    end

    if (keep) begin
      select_code_d  = select_code_q;
      grant_onehot_d = grant_onehot_q;
      grant_valid_d  = 1'b1;
      hold_cnt_d     = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end else if (found) begin
      cur_d          = winner;
      select_code_d  = SEL_W'(winner);
      grant_onehot_d = NUM_SRC'(1) << winner;
      grant_valid_d  = 1'b1;
      ptr_d          = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr_q          <= '0;
      cur_q          <= '0;
      hold_cnt_q     <= '0;
      select_code_q  <= IDLE_CODE;
      grant_onehot_q <= '0;
      grant_valid_q  <= 1'b0;
      conflict_q     <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      cur_q          <= cur_d;
      hold_cnt_q     <= hold_cnt_d;
      select_code_q  <= select_code_d;
      grant_onehot_q <= grant_onehot_d;
      grant_valid_q  <= grant_valid_d;
      conflict_q     <= conflict_d;
    end
  end

  assign bus.select_code  = select_code_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.conflict     = conflict_q;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Scoreboard bench for bus_select_arbiter: directed vectors push hand-computed grants,
// a monitor pops one expectation per cycle and compares all four outputs.
module tb_bus_select_arbiter;
  localparam int N = 24;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  bus_select_arbiter_if #(.NUM_SRC(N), .SEL_W(5)) bus ();

  bus_select_arbiter #(
    .NUM_SRC(N), .SEL_W(5), .MAX_HOLD(8), .IDLE_CODE(5'b11111)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // idx = expected granted source, -1 = idle
  typedef struct {
    int   idx;
    logic conf;
    int   tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tag_cnt  = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic conf);
    exp_t e;
    e.idx  = idx;
    e.conf = conf;
    e.tag  = tag_cnt;
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic h, input int idx, input logic conf);
    @(negedge clk);
    bus.req  = r;
    bus.hold = h;
    push(idx, conf);
  endtask

  // Monitor: outputs are presented every cycle, one expectation consumed per edge.
  always @(posedge clk) begin
    exp_t          e;
    logic [N-1:0]  exp_oh;
    logic [4:0]    exp_sel;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.idx < 0) begin
        exp_oh  = '0;
        exp_sel = 5'h1f;
      end else begin
        exp_oh  = N'(1) << e.idx;
        exp_sel = 5'(e.idx);
      end
      check("select_code",  e.tag, 32'(bus.select_code),  32'(exp_sel));
      check("grant_onehot", e.tag, 32'(bus.grant_onehot), 32'(exp_oh));
      check("grant_valid",  e.tag, 32'(bus.grant_valid),  32'(e.idx >= 0));
      check("conflict",     e.tag, 32'(bus.conflict),     32'(e.conf));
    end
  end

  logic [N-1:0] rr;
  logic [N-1:0] hl;

  initial begin
    bus.req  = '0;
    bus.hold = 1'b0;
    rr = (N'(1) << 3) | (N'(1) << 7) | (N'(1) << 21);
    hl = (N'(1) << 5) | (N'(1) << 9);

    // Reset values
    #12;
    check("rst_select_code",  -1, 32'(bus.select_code),  32'h1f);
    check("rst_grant_onehot", -1, 32'(bus.grant_onehot), 32'h0);
    check("rst_grant_valid",  -1, 32'(bus.grant_valid),  32'h0);
    check("rst_conflict",     -1, 32'(bus.conflict),     32'h0);
    @(negedge clk);
    clr_n = 1'b1;

    // Round robin from reset (ptr = 0): 3, 7, 21, 3, 7, 21
    for (int k = 0; k < 2; k++) begin
      step(rr, 1'b0, 3, 1'b1);
      step(rr, 1'b0, 7, 1'b1);
      step(rr, 1'b0, 21, 1'b1);
    end
    step('0, 1'b0, -1, 1'b0);

    // Single request (PC), then idle
    step(N'(1) << 20, 1'b0, 20, 1'b0);
    step('0, 1'b0, -1, 1'b0);

    // Wrap-around: 23 moves ptr to 0, then {0,22} grants 0 then 22
    step(N'(1) << 23, 1'b0, 23, 1'b0);
    step((N'(1) << 0) | (N'(1) << 22), 1'b0, 0, 1'b1);
    step((N'(1) << 0) | (N'(1) << 22), 1'b0, 22, 1'b1);
    step('0, 1'b0, -1, 1'b0);

    // Hold limit: ptr = 23, so 5 wins first; 8 cycles each, then 5 again
    for (int k = 0; k < 8; k++) step(hl, 1'b1, 5, 1'b1);
    for (int k = 0; k < 8; k++) step(hl, 1'b1, 9, 1'b1);
    step(hl, 1'b1, 5, 1'b1);
    step('0, 1'b0, -1, 1'b0);

    // Owner drops under hold: 12 held, req[12] drops with req[2] pending -> 2
    step(N'(1) << 12, 1'b1, 12, 1'b0);
    step((N'(1) << 12) | (N'(1) << 2), 1'b1, 12, 1'b1);
    step(N'(1) << 2, 1'b1, 2, 1'b0);
    // hold_cnt restarted: 2 kept 7 more cycles against 12, then 12 takes over
    for (int k = 0; k < 7; k++) step((N'(1) << 2) | (N'(1) << 12), 1'b1, 2, 1'b1);
    step((N'(1) << 2) | (N'(1) << 12), 1'b1, 12, 1'b1);
    step('0, 1'b0, -1, 1'b0);

    // Lone requester: re-granted without hold, held past MAX_HOLD without contention
    for (int k = 0; k < 3; k++)  step(N'(1) << 4, 1'b0, 4, 1'b0);
    for (int k = 0; k < 12; k++) step(N'(1) << 4, 1'b1, 4, 1'b0);

    // Reset mid-grant: asynchronous, outputs drop immediately
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check("midrst_select_code",  -2, 32'(bus.select_code),  32'h1f);
    check("midrst_grant_onehot", -2, 32'(bus.grant_onehot), 32'h0);
    check("midrst_grant_valid",  -2, 32'(bus.grant_valid),  32'h0);
    check("midrst_conflict",     -2, 32'(bus.conflict),     32'h0);
    @(negedge clk);
    clr_n    = 1'b1;
    bus.req  = N'(1) << 4;
    bus.hold = 1'b0;
    push(4, 1'b0);
    step('0, 1'b0, -1, 1'b0);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    check("scoreboard_drain", -3, 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_select_arbiter.md
# bus_select_arbiter

- Drives the 5-bit bus select code consumed by the datapath bus multiplexer.
- Collects one-hot "drive bus" requests from the 24 bus sources, grants exactly one per cycle with round-robin fairness, and encodes the winner into the select code.
- Supports multi-cycle bus ownership via `hold`, with a bounded hold limit so no source starves.
- Sits between the control unit's out-enable signals and the bus multiplexer select input.

## Interface
Parameters:
- NUM_SRC, 24: number of bus sources; source index i maps to select code i.
- SEL_W, 5: select code width.
- MAX_HOLD, 8: maximum consecutive granted cycles for one source while another source is pending.
- IDLE_CODE, 5'b11111: select code driven when nothing is granted. Codes 24–31 make the multiplexer output 0.

Ports (clock and reset are one clock domain; reset is asynchronous, active-low):
- clk, input, 1: rising-edge clock.
- clr_n, input, 1: asynchronous active-low reset.
- req, input, NUM_SRC: per-source bus request. Bit i order: r0..r15 = 0..15, HI = 16, LO = 17, Z_HI = 18, Z_LO = 19, PC = 20, MDR = 21, InPort = 22, C_sign_ext = 23.
- hold, input, 1: current owner requests to keep the bus next cycle.
- select_code, output, SEL_W: registered encoded select for the bus multiplexer.
- grant_onehot, output, NUM_SRC: registered one-hot grant, matches select_code.
- grant_valid, output, 1: registered; 1 when a source is granted.
- conflict, output, 1: registered; 1 when more than one req bit was set on the previous edge.

## Operation
Internal state:
- ptr: round-robin start index, range 0..NUM_SRC-1.
- cur: granted index.
- hold_cnt: consecutive-grant counter, saturating at MAX_HOLD-1.

At each rising edge, evaluate in this priority order:
- **KEEP**: applies if grant_valid && hold && req[cur], and NOT (hold_cnt == MAX_HOLD-1 && any req bit other than cur set).
  - Grant outputs unchanged.
  - hold_cnt increments, saturating.
  - ptr unchanged.
- **ARBITRATE**: otherwise, if req is nonzero.
  - Winner = first set bit scanning ptr, ptr+1, …, NUM_SRC-1, 0, …, ptr-1.
  - cur = winner; grant_onehot = 1<<winner; select_code = winner; grant_valid = 1.
  - hold_cnt = 0.
  - ptr = winner+1, wrapping NUM_SRC-1 → 0.
- **IDLE**: otherwise (req is zero, or the owner dropped req).
  - grant_valid = 0; grant_onehot = 0; select_code = IDLE_CODE; hold_cnt = 0; ptr unchanged.

Other rules:
- conflict is registered every edge from popcount(req) > 1, independent of the branch taken.
- Forced release: when KEEP is denied by the hold limit, ARBITRATE runs with ptr = cur+1, so a different pending source wins.
- Owner drops req while hold is high: ARBITRATE (if others are pending) or IDLE. There is no stale grant.
- Without hold, every edge re-arbitrates. A lone requester is re-granted each cycle.
- Invariants: grant_onehot has at most one bit set; select_code equals the index of that bit, or IDLE_CODE when grant_valid = 0.

## Timing
- Reset (clr_n low, asynchronous, takes effect immediately):
  - select_code = IDLE_CODE, grant_onehot = 0, grant_valid = 0, conflict = 0.
  - ptr = 0, cur = 0, hold_cnt = 0.
- Release of clr_n is sampled synchronously. The first arbitration is on the first rising edge with clr_n high.
- Latency: req sampled at edge N → grant visible after edge N, valid for cycle N+1. All outputs are flops; no combinational path from inputs to outputs.
- Held ownership under contention: at most MAX_HOLD consecutive cycles. Without contention, unlimited.
- Reset mid-grant: outputs return to reset values immediately, with no glitch to another source code.
- Simultaneous hold-limit expiry and owner req drop: treated as ARBITRATE. Result is identical either way.

## Test plan
- **Reset**: assert clr_n = 0 mid-run with req = 24'h000010 granted → outputs immediately select_code = 5'b11111, grant_valid = 0, grant_onehot = 0, conflict = 0.
- **Single request**: req = bit 20 (PC) for one edge → next cycle select_code = 5'd20, grant_onehot = 24'h100000, grant_valid = 1, conflict = 0. req = 0 on the following edge → IDLE_CODE.
- **Round robin**: hold = 0, req = bits {3, 7, 21} held constant from reset → grants cycle 3, 7, 21, 3, 7, … with conflict = 1 every cycle.
- **Hold limit**: req = bits {5, 9}, hold = 1 continuously, 5 granted first → 5 held exactly 8 cycles, then 9 granted for 8 cycles, then 5 again.
- **Wrap-around**: grant 23 (C_sign_ext), then req = bits {0, 22}, hold = 0 → 0 wins (ptr wrapped to 0), then 22.
- **Owner drops under hold**: 12 granted, hold = 1, req[12] drops while req[2] is set → next cycle select_code = 5'd2, hold_cnt restarts.
